// File: rtl/lstm_acc_pkg.sv
// rtl/lstm_acc_pkg.sv - shared types and defaults for the sys_out read path
// Drain FSM state encoding, array geometry defaults and address-width helper.
package lstm_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int DEF_M      = 9;
  localparam int DEF_GAMMA  = 3;
  localparam int DEF_DATA_W = 16;

  function automatic int addr_w(input int feature_bits);
    return 2 * feature_bits;
  endfunction

endpackage

// File: rtl/sys_out_rd_if.sv
// rtl/sys_out_rd_if.sv - DPR read port and result stream bundle
// master: the drain engine; slave: the DPR plus downstream consumer.
interface sys_out_rd_if
  import lstm_acc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int AW     = addr_w(4)
);

  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_row_last;
  logic              out_last;

  modport master (
    output rd_en, rd_addr, out_data, out_valid, out_row_last, out_last,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_data, out_valid, out_row_last, out_last,
    output rd_data, out_ready
  );

endinterface

// File: rtl/sys_out_skid.sv
// rtl/sys_out_skid.sv - two-entry FIFO holding a word plus its sideband bits
// Caller guarantees no push when full and no pop when empty.
module sys_out_skid #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;

  always_comb begin
    count_d = count_q + 2'(push_i) - 2'(pop_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/sys_out_rd.sv
// rtl/sys_out_rd.sv - drains the sys_out DPR as a ready/valid word stream
// Reads addresses 0..N-1 in gamma-major order, never more than two words ahead of the consumer.
module sys_out_rd
  import lstm_acc_pkg::*;
#(
  parameter int FEATURE_BITS = 4,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int M            = DEF_M,
  parameter int GAMMA        = DEF_GAMMA
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  sys_out_rd_if.master bus
);

  localparam int AW = addr_w(FEATURE_BITS);
  localparam int N  = M * GAMMA;
  localparam int MW = $clog2(M + 1);
  localparam int GW = $clog2(GAMMA + 1);
  localparam logic [AW-1:0] M_A = AW'(M);

  if ((N - 1) >= (1 << AW)) begin : g_addr_chk
    $error("sys_out_rd: N-1 does not fit in the address width");
  end

  state_e          state_q, state_d;
  logic [MW-1:0]   m_q, m_d;
  logic [GW-1:0]   g_q, g_d;
  logic            infl_q;
  logic            infl_row_last_q;
  logic            infl_last_q;
  logic            done_q;

  logic [AW-1:0]   addr_cur;
  logic            cur_row_last;
  logic            cur_last;
  logic            issue;
  logic            pop;
  logic [DATA_W+1:0] head;
  logic            head_valid;
  logic [1:0]      count;
  logic [2:0]      occ;

  assign addr_cur     = AW'(g_q) * M_A + AW'(m_q);
  assign cur_row_last = (m_q == MW'(M - 1));
  assign cur_last     = cur_row_last && (g_q == GW'(GAMMA - 1));
  assign pop          = head_valid & bus.out_ready;
  // Words buffered plus the one possibly returning from the DPR this cycle.
  assign occ          = {1'b0, count} + {2'b00, infl_q};

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    g_d     = g_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          m_d     = '0;
          g_d     = '0;
        end
      end
      ST_READ: begin
        issue = (occ < (3'd2 + {2'b00, pop}));
        if (issue) begin
          if (cur_last) begin
            state_d = ST_DRAIN;
          end else if (cur_row_last) begin
            m_d = '0;
            g_d = g_q + GW'(1);
          end else begin
            m_d = m_q + MW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (pop && head[0]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      m_q             <= '0;
      g_q             <= '0;
      infl_q          <= 1'b0;
      infl_row_last_q <= 1'b0;
      infl_last_q     <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      m_q             <= m_d;
      g_q             <= g_d;
      infl_q          <= issue;
      infl_row_last_q <= issue & cur_row_last;
      infl_last_q     <= issue & cur_last;
      done_q          <= (state_q == ST_DRAIN) && pop && head[0];
    end
  end

  sys_out_skid #(
    .W (DATA_W + 2)
  ) u_skid (
    .clk         (sys_clk),
    .rst         (reset),
    .push_i      (infl_q),
    .push_data_i ({bus.rd_data, infl_row_last_q, infl_last_q}),
    .pop_i       (pop),
    .head_o      (head),
    .valid_o     (head_valid),
    .count_o     (count)
  );

  assign bus.rd_en        = issue;
  assign bus.rd_addr      = issue ? addr_cur : '0;
  assign bus.out_valid    = head_valid;
  assign bus.out_data     = head_valid ? head[DATA_W+1:2] : '0;
  assign bus.out_row_last = head_valid & head[1];
  assign bus.out_last     = head_valid & head[0];
  assign busy             = (state_q != ST_IDLE);
  assign done             = done_q;

endmodule

// File: tb/tb_sys_out_rd.sv
// tb/tb_sys_out_rd.sv - directed self-checking bench for sys_out_rd
// DPR model returns addr+100 one cycle after rd_en.
module tb_sys_out_rd;

  logic sys_clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;

  sys_out_rd_if bus ();

  sys_out_rd dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    bus.rd_data <= bus.rd_en ? (16'(bus.rd_addr) + 16'd100) : 16'hDEAD;
  end

  int errors = 0;
  int checks = 0;

  int words[$];
  bit rls[$];
  bit lsts[$];
  int acc_cyc[$];
  int raddr[$];
  int rcyc[$];
  int done_cnt, done_cyc, first_valid, stall_viol, addr_viol, max_out;
  bit busy_at_done, timed_out;

  function automatic bit rdy(input int mode, input int i);
    case (mode)
      1:       return (i % 4 == 0) || (i % 4 == 3);
      2:       return (i >= 20);
      default: return 1'b1;
    endcase
  endfunction

  task automatic drain(input int mode, input int s2_word, input int rst_word,
                       input int want_done, input bit chain);
    int issued, outst;
    bit held, s2_done, held_rl, held_l;
    logic [15:0] held_d;
    words.delete(); rls.delete(); lsts.delete(); acc_cyc.delete();
    raddr.delete(); rcyc.delete();
    done_cnt = 0; done_cyc = -1; first_valid = -1; stall_viol = 0;
    addr_viol = 0; max_out = 0; busy_at_done = 0; timed_out = 1;
    issued = 0; held = 0; s2_done = 0; held_d = '0; held_rl = 0; held_l = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sys_clk);
      if (i == 0) start = 1'b1;
      else if (s2_word >= 0 && !s2_done && words.size() == s2_word) begin
        start = 1'b1;
        s2_done = 1'b1;
      end else start = 1'b0;
      bus.out_ready = rdy(mode, i);
      #1;
      if (bus.rd_en) begin
        raddr.push_back(int'(bus.rd_addr));
        rcyc.push_back(i);
        issued++;
      end else if (bus.rd_addr != '0) addr_viol++;
      if (held && (!bus.out_valid || bus.out_data !== held_d ||
                   bus.out_row_last !== held_rl || bus.out_last !== held_l))
        stall_viol++;
      held    = bus.out_valid && !bus.out_ready;
      held_d  = bus.out_data;
      held_rl = bus.out_row_last;
      held_l  = bus.out_last;
      if (bus.out_valid && first_valid < 0) first_valid = i;
      if (bus.out_valid && bus.out_ready) begin
        words.push_back(int'(bus.out_data));
        rls.push_back(bus.out_row_last);
        lsts.push_back(bus.out_last);
        acc_cyc.push_back(i);
      end
      outst = issued - words.size();
      if (outst > max_out) max_out = outst;
      if (done) begin
        done_cnt++;
        done_cyc = i;
        if (busy) busy_at_done = 1'b1;
        if (chain && done_cnt < want_done) start = 1'b1;
      end
      if ((want_done > 0 && done_cnt == want_done) ||
          (rst_word >= 0 && words.size() == rst_word)) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(negedge sys_clk);
    #1;
    checks++;
    if ({bus.rd_en, bus.rd_addr, bus.out_valid, bus.out_data, bus.out_row_last,
         bus.out_last, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b addr=%0d v=%b d=%0d rl=%b l=%b busy=%b done=%b, want all 0",
               bus.rd_en, bus.rd_addr, bus.out_valid, bus.out_data, bus.out_row_last,
               bus.out_last, busy, done);
    end
    reset = 1'b0;
    @(negedge sys_clk); #1;
    checks++;
    if (busy !== 1'b0 || bus.rd_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b rd_en=%b, want 0 0", busy, bus.rd_en);
    end
  endtask

  task automatic test_stream();
    drain(0, -1, -1, 1, 0);
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL stream_timeout: no done within budget");
    end
    checks++;
    if (rcyc.size() < 1 || rcyc[0] != 1 || raddr[0] != 0) begin
      errors++;
      $display("FAIL stream_first_read: got %0d reads, first cycle %0d, want addr 0 at cycle 1",
               rcyc.size(), rcyc.size() ? rcyc[0] : -1);
    end
    checks++;
    if (first_valid != 3) begin
      errors++;
      $display("FAIL stream_latency: first out_valid %0d, want 3", first_valid);
    end
    checks++;
    if (words.size() != 27) begin
      errors++;
      $display("FAIL stream_count: got %0d words, want 27", words.size());
    end
    for (int k = 0; k < words.size() && k < 27; k++) begin
      checks++;
      if (words[k] != k + 100 || acc_cyc[k] != 3 + k || rls[k] != (k % 9 == 8) ||
          lsts[k] != (k == 26) || raddr[k] != k) begin
        errors++;
        $display("FAIL stream_word%0d: data=%0d cyc=%0d rl=%b l=%b addr=%0d, want %0d %0d %b %b %0d",
                 k, words[k], acc_cyc[k], rls[k], lsts[k], raddr[k],
                 k + 100, 3 + k, (k % 9 == 8), (k == 26), k);
      end
    end
    checks++;
    if (done_cyc != 30 || busy_at_done) begin
      errors++;
      $display("FAIL stream_done: done at %0d busy=%b, want 30 busy=0", done_cyc, busy_at_done);
    end
    checks++;
    if (addr_viol != 0) begin
      errors++;
      $display("FAIL stream_addr_idle: %0d nonzero rd_addr with rd_en low, want 0", addr_viol);
    end
  endtask

  task automatic test_stall_pattern();
    drain(1, -1, -1, 1, 0);
    checks++;
    if (timed_out || words.size() != 27) begin
      errors++;
      $display("FAIL pattern_count: got %0d words timeout=%b, want 27", words.size(), timed_out);
    end
    for (int k = 0; k < words.size() && k < 27; k++) begin
      checks++;
      if (words[k] != k + 100 || rls[k] != (k % 9 == 8) || lsts[k] != (k == 26)) begin
        errors++;
        $display("FAIL pattern_word%0d: data=%0d rl=%b l=%b, want %0d %b %b",
                 k, words[k], rls[k], lsts[k], k + 100, (k % 9 == 8), (k == 26));
      end
    end
    checks++;
    if (stall_viol != 0) begin
      errors++;
      $display("FAIL pattern_stable: %0d stall changes, want 0", stall_viol);
    end
    checks++;
    if (max_out > 2) begin
      errors++;
      $display("FAIL pattern_outstanding: max %0d, want <=2", max_out);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL pattern_done: got %0d, want 1", done_cnt);
    end
  endtask

  task automatic test_hold();
    int early;
    drain(2, -1, -1, 1, 0);
    early = 0;
    foreach (rcyc[k]) if (rcyc[k] < 20) early++;
    checks++;
    if (early != 2 || raddr.size() < 2 || raddr[0] != 0 || raddr[1] != 1) begin
      errors++;
      $display("FAIL hold_reads: %0d reads while stalled, want 2 at addr 0,1", early);
    end
    checks++;
    if (timed_out || words.size() != 27 || words[0] != 100 || words[words.size()-1] != 126) begin
      errors++;
      $display("FAIL hold_count: got %0d words, want 27 from 100 to 126", words.size());
    end
    checks++;
    if (stall_viol != 0) begin
      errors++;
      $display("FAIL hold_stable: %0d stall changes, want 0", stall_viol);
    end
  endtask

  task automatic test_start_busy();
    int bad;
    drain(0, 10, -1, 1, 0);
    checks++;
    if (timed_out || words.size() != 27) begin
      errors++;
      $display("FAIL busy_start_count: got %0d words, want 27", words.size());
    end
    bad = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge sys_clk); start = 1'b0; #1;
      if (busy || bus.rd_en || done) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL busy_start_ignored: %0d active cycles after done, want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    drain(0, -1, 13, 0, 0);
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL midreset_reach: got %0d words, want 13", words.size());
    end
    reset = 1'b1;
    @(negedge sys_clk); #1;
    checks++;
    if ({bus.rd_en, bus.rd_addr, bus.out_valid, bus.out_data, bus.out_row_last,
         bus.out_last, busy, done} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: en=%b v=%b d=%0d busy=%b, want 0 0 0 0",
               bus.rd_en, bus.out_valid, bus.out_data, busy);
    end
    reset = 1'b0;
    drain(0, -1, -1, 1, 0);
    checks++;
    if (raddr.size() < 1 || raddr[0] != 0 || first_valid != 3) begin
      errors++;
      $display("FAIL midreset_restart: first addr %0d first valid %0d, want 0 3",
               raddr.size() ? raddr[0] : -1, first_valid);
    end
    checks++;
    if (timed_out || words.size() != 27 || words[0] != 100 || words[words.size()-1] != 126) begin
      errors++;
      $display("FAIL midreset_count: got %0d words, want 27 from 100 to 126", words.size());
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    drain(0, -1, -1, 2, 1);
    checks++;
    if (timed_out || done_cnt != 2 || words.size() != 54) begin
      errors++;
      $display("FAIL b2b_count: %0d words %0d dones, want 54 2", words.size(), done_cnt);
    end
    bad = 0;
    foreach (words[k]) if (words[k] != (k % 27) + 100 || lsts[k] != (k % 27 == 26)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_order: %0d wrong words, want 0", bad);
    end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    start = 1'b0;
    test_reset();
    test_stream();
    test_stall_pattern();
    test_hold();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sys_out_rd.md
SYS_OUT_RD -- requirements
Module: sys_out_rd

Interface
REQ-001 Parameter FEATURE_BITS, default 4, feature-count bit width; address width is 2*FEATURE_BITS.
REQ-002 Parameter DATA_W, default 16, width of one sys_out DPR word.
REQ-003 Parameter M, default 9, words per gamma block (row length).
REQ-004 Parameter GAMMA, default 3, number of gamma blocks; total words N = M*GAMMA (default 27).
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-006 sys_clk  input  1  systolic array clock; all state on rising edge.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 start  input  1  one-cycle pulse from the sys_out writer's done rise; begins one full drain.
REQ-009 rd_en  output  1  DPR read enable.
REQ-010 rd_addr  output  2*FEATURE_BITS  DPR read address.
REQ-011 rd_data  input  DATA_W  DPR read data, valid exactly one cycle after rd_en.
REQ-012 out_data  output  DATA_W  streamed result word.
REQ-013 out_valid  output  1  out_data valid.
REQ-014 out_ready  input  1  downstream accepts when out_valid & out_ready.
REQ-015 out_row_last  output  1  presented word is last of its M-word block.
REQ-016 out_last  output  1  presented word is address N-1.
REQ-017 busy  output  1  drain in progress (state != IDLE).
REQ-018 done  output  1  one-cycle pulse after final word accepted.

Function
REQ-019 FSM states: IDLE, READ, DRAIN; IDLE->READ on start; READ->DRAIN after read of address N-1 issued; DRAIN->IDLE when final word accepted.
REQ-020 Read address SHALL be gamma_idx*M + m_idx, m_idx wrapping M-1->0 and incrementing gamma_idx, i.e. 0..N-1 sequentially, matching the writer's expansion ordering.
REQ-021 rd_en SHALL assert in READ only when (buffer occupancy + reads in flight - pop this cycle) < 2; a read is in flight the cycle after rd_en.
REQ-022 rd_data SHALL be pushed into a 2-entry FIFO the cycle after rd_en; out_data/out_valid come from the FIFO head.
REQ-023 Latency: start sampled at edge t -> rd_en/addr 0 in cycle t+1 -> out_valid in cycle t+3.
REQ-024 With out_ready held high, throughput SHALL be one word per cycle, no bubbles.
REQ-025 While out_valid & !out_ready, out_data, out_row_last, out_last SHALL hold stable; no word dropped or duplicated.
REQ-026 out_row_last and out_last SHALL travel with their word through the FIFO (sidebands stored per entry).
REQ-027 done SHALL pulse in the cycle after the handshake of the out_last word; busy deasserts in that same cycle.
REQ-028 start while busy SHALL be ignored; start in the done cycle SHALL be accepted.
REQ-029 Address arithmetic is unsigned, 2*FEATURE_BITS wide; N-1 SHALL fit (elaboration error otherwise).
REQ-030 rd_addr SHALL be 0 whenever rd_en is low.

Reset
REQ-031 On reset: state IDLE, counters 0, FIFO empty, in-flight cleared; rd_en, rd_addr, out_valid, out_row_last, out_last, busy, done = 0; out_data = 0.
REQ-032 Reset mid-drain SHALL abort immediately; a returning rd_data after reset SHALL be discarded.

Structure
REQ-033 Shared package lstm_acc_pkg SHALL hold the state enum and the M, GAMMA, DATA_W defaults and address-width function.
REQ-034 One sub-module, sys_out_skid: 2-entry FIFO with data+2 sideband bits, push/pop, count output.

Verification
REQ-035 Reset, start, out_ready=1, DPR[i]=i+100 -> out_data 100..126 on consecutive cycles, first out_valid at t+3, out_row_last at words 8,17,26, out_last at 26, done at next cycle.
REQ-036 out_ready toggled 1,0,0,1 repeating -> all 27 words in order, data stable during stalls, rd_en never exceeds 2 outstanding.
REQ-037 out_ready=0 for 20 cycles after start -> exactly 2 reads issued (addr 0,1), then stall; release -> remaining 25 follow.
REQ-038 Second start pulse at word 10 -> ignored; exactly 27 words, one done.
REQ-039 Reset asserted at word 13 -> all outputs 0 next cycle; new start -> drain restarts at address 0.
REQ-040 start coincident with done -> second full 27-word drain follows without loss.
